// File: rtl/tdnn_pkg.sv
// ---------------------------------------------------------------------------
// tdnn_pkg
// Purpose : definitions shared between the weight/bias loader and the neurons
//           it feeds: default word width and fan-in, default neuron count,
//           the loader FSM state type and a counter-width helper.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package tdnn_pkg;

  localparam int WEIGHT_SIZE_DEF = 16;
  localparam int NUM_INPUTS_DEF  = 3;
  localparam int NUM_NEURONS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_FINISH  = 2'd3
  } loader_state_t;

  // Width of a counter that must hold the values 0 .. count-1.
  // Never returns 0 so a single-neuron build still has a legal vector.
  function automatic int cnt_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/neuron_wb_loader_if.sv
// ---------------------------------------------------------------------------
// neuron_wb_loader_if
// Purpose : bundles the coefficient stream handshake and the weight/bias
//           broadcast bus of the neuron weight/bias loader.
// Signals : START, DATA_IN, DATA_VALID   - driven by the coefficient source
//           DATA_READY                   - loader accepts a word this cycle
//           WEIGHTS_OUT, BIAS_OUT        - shared shadow registers to neurons
//           WB_EN                        - one-hot per-neuron write enable
//           BUSY, DONE                   - sequence status / completion pulse
// Modports: master = coefficient source / neuron side, slave = the loader.
// ---------------------------------------------------------------------------
interface neuron_wb_loader_if
  import tdnn_pkg::*;
#(
  parameter int WEIGHT_SIZE = WEIGHT_SIZE_DEF,
  parameter int NUM_INPUTS  = NUM_INPUTS_DEF,
  parameter int NUM_NEURONS = NUM_NEURONS_DEF
) ();

  logic                                        START;
  logic signed [WEIGHT_SIZE-1:0]               DATA_IN;
  logic                                        DATA_VALID;
  logic                                        DATA_READY;
  logic signed [NUM_INPUTS-1:0][WEIGHT_SIZE-1:0] WEIGHTS_OUT;
  logic signed [WEIGHT_SIZE-1:0]               BIAS_OUT;
  logic [NUM_NEURONS-1:0]                      WB_EN;
  logic                                        BUSY;
  logic                                        DONE;

  modport master (
    output START, DATA_IN, DATA_VALID,
    input  DATA_READY, WEIGHTS_OUT, BIAS_OUT, WB_EN, BUSY, DONE
  );

  modport slave (
    input  START, DATA_IN, DATA_VALID,
    output DATA_READY, WEIGHTS_OUT, BIAS_OUT, WB_EN, BUSY, DONE
  );

endinterface

// File: rtl/neuron_wb_loader.sv
// ---------------------------------------------------------------------------
// neuron_wb_loader
// Purpose : streams NUM_INPUTS weights plus one bias per neuron from a
//           valid/ready word source into shared shadow registers and pulses
//           a one-hot write enable so neuron n latches its coefficients.
//           Neurons are loaded 0 .. NUM_NEURONS-1; DONE pulses at the end.
// Ports   : CLOCK_N - clock, all state changes on its falling edge
//           RESET   - synchronous active-high reset
//           bus     - neuron_wb_loader_if slave modport (handshake + buses)
// ---------------------------------------------------------------------------
module neuron_wb_loader
  import tdnn_pkg::*;
#(
  parameter int WEIGHT_SIZE = WEIGHT_SIZE_DEF,
  parameter int NUM_INPUTS  = NUM_INPUTS_DEF,
  parameter int NUM_NEURONS = NUM_NEURONS_DEF
) (
  input logic               CLOCK_N,
  input logic               RESET,
  neuron_wb_loader_if.slave bus
);

  localparam int WORD_W = cnt_width(NUM_INPUTS + 1);
  localparam int NRN_W  = cnt_width(NUM_NEURONS);
  localparam logic [WORD_W-1:0] BIAS_SLOT = WORD_W'(NUM_INPUTS);
  localparam logic [NRN_W-1:0]  LAST_NRN  = NRN_W'(NUM_NEURONS - 1);

  loader_state_t                 state_reg;
  loader_state_t                 state_next;
  logic [WORD_W-1:0]             word_cnt_reg;
  logic [NRN_W-1:0]              neuron_cnt_reg;
  logic                          done_reg;
  logic signed [WEIGHT_SIZE-1:0] weight_reg [NUM_INPUTS];
  logic signed [WEIGHT_SIZE-1:0] bias_reg;

  logic accept;
  logic start_ok;
  logic last_word;
  logic last_neuron;

  assign accept      = (state_reg == ST_COLLECT) && bus.DATA_VALID;
  assign last_word   = (word_cnt_reg == BIAS_SLOT);
  assign last_neuron = (neuron_cnt_reg == LAST_NRN);
  // The completion pulse is still part of the sequence, so a START landing
  // on that cycle is not taken as a new request.
  assign start_ok    = (state_reg == ST_IDLE) && !done_reg && bus.START;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (start_ok) state_next = ST_COLLECT;
      ST_COLLECT: if (accept && last_word) state_next = ST_COMMIT;
      ST_COMMIT:  state_next = last_neuron ? ST_FINISH : ST_COLLECT;
      ST_FINISH:  state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(negedge CLOCK_N) begin
    if (RESET) begin
      state_reg      <= ST_IDLE;
      word_cnt_reg   <= '0;
      neuron_cnt_reg <= '0;
      done_reg       <= 1'b0;
      bias_reg       <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) weight_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      // DONE is registered off FINISH, so it appears on the edge that
      // leaves FINISH and lasts exactly one cycle.
      done_reg  <= (state_reg == ST_FINISH);

      if (start_ok) begin
        word_cnt_reg   <= '0;
        neuron_cnt_reg <= '0;
      end else if (accept && !last_word) begin
        word_cnt_reg <= word_cnt_reg + 1'b1;
      end else if ((state_reg == ST_COMMIT) && !last_neuron) begin
        neuron_cnt_reg <= neuron_cnt_reg + 1'b1;
        word_cnt_reg   <= '0;
      end

      // Shadow registers only change on an accepted word, so they hold
      // steady through COMMIT while the addressed neuron latches them.
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (accept && (word_cnt_reg == WORD_W'(i))) weight_reg[i] <= bus.DATA_IN;
      end
      if (accept && last_word) bias_reg <= bus.DATA_IN;
    end
  end

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_weights
    assign bus.WEIGHTS_OUT[gi] = weight_reg[gi];
  end

  for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_wb_en
    assign bus.WB_EN[gi] = (state_reg == ST_COMMIT) && (neuron_cnt_reg == NRN_W'(gi));
  end

  assign bus.BIAS_OUT   = bias_reg;
  assign bus.DATA_READY = (state_reg == ST_COLLECT);
  assign bus.BUSY       = (state_reg != ST_IDLE) || done_reg;
  assign bus.DONE       = done_reg;

endmodule

// File: tb/tb_neuron_wb_loader.sv
// ---------------------------------------------------------------------------
// tb_neuron_wb_loader
// Purpose : self-checking bench for neuron_wb_loader. Each load sequence is
//           first expanded into an expected cycle-by-cycle schedule built from
//           the loading rules (words per neuron, stall cycles, one commit
//           cycle per neuron, finish, done pulse), then replayed against the
//           DUT. Outputs are sampled on the rising edge, away from the active
//           falling edge; inputs are driven on the rising edge too.
// ---------------------------------------------------------------------------
module tb_neuron_wb_loader;
  import tdnn_pkg::*;

  localparam int WS = WEIGHT_SIZE_DEF;
  localparam int NI = NUM_INPUTS_DEF;
  localparam int NN = NUM_NEURONS_DEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neuron_wb_loader_if #(.WEIGHT_SIZE(WS), .NUM_INPUTS(NI), .NUM_NEURONS(NN)) bus ();

  neuron_wb_loader #(.WEIGHT_SIZE(WS), .NUM_INPUTS(NI), .NUM_NEURONS(NN)) dut (
    .CLOCK_N (clk),
    .RESET   (rst),
    .bus     (bus)
  );

  typedef struct {
    bit                     ready;
    bit                     busy;
    bit                     done;
    logic [NN-1:0]          wben;
    bit                     valid;
    logic [WS-1:0]          data;
    int                     nrn;
    bit                     commit;
    logic [NI-1:0][WS-1:0]  w;
    logic [WS-1:0]          b;
  } step_t;

  step_t sched[$];
  int checks = 0;
  int errors = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic step_t mk(input bit ready, input bit busy, input bit done,
                               input logic [NN-1:0] wben, input bit valid,
                               input logic [WS-1:0] data, input int nrn);
    step_t s;
    s.ready = ready; s.busy = busy; s.done = done; s.wben = wben;
    s.valid = valid; s.data = data; s.nrn = nrn;
    s.commit = 1'b0; s.w = '0; s.b = '0;
    return s;
  endfunction

  // Idle cycles inserted before word k of neuron n.
  function automatic int stall_len(input int mode, input int n, input int k);
    if (mode == 1) return (n == 1 && (k == 1 || k == 2)) ? 1 : 0;
    if (mode == 2) return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    return 0;
  endfunction

  // Expected schedule: entry i is what the outputs must show after the
  // i-th falling edge following the edge that samples START.
  task automatic build_seq(input int mode);
    logic [NI-1:0][WS-1:0] w;
    logic [WS-1:0]         b;
    logic [WS-1:0]         word;
    logic [NN-1:0]         oh;
    step_t                 s;
    int                    stall;
    sched.delete();
    for (int n = 0; n < NN; n++) begin
      for (int k = 0; k < NI; k++) w[k] = WS'($urandom);
      b = WS'($urandom);
      if (mode == 3 && n == 1) begin
        w[2] = 16'h8000;
        b    = 16'h7FFF;
      end else if (mode == 0) begin
        for (int k = 0; k < NI; k++) w[k] = WS'(n * (NI + 1) + k + 1);
        b = WS'(n * (NI + 1) + NI + 1);
      end
      for (int k = 0; k <= NI; k++) begin
        word  = (k < NI) ? w[k] : b;
        stall = stall_len(mode, n, k);
        for (int j = 0; j < stall; j++) sched.push_back(mk(1, 1, 0, '0, 1'b0, WS'($urandom), n));
        sched.push_back(mk(1, 1, 0, '0, 1'b1, word, n));
      end
      oh = '0;
      oh[n] = 1'b1;
      s = mk(0, 1, 0, oh, 1'($urandom), WS'($urandom), n);
      s.commit = 1'b1; s.w = w; s.b = b;
      sched.push_back(s);
    end
    sched.push_back(mk(0, 1, 0, '0, 1'($urandom), WS'($urandom), NN));  // finish
    sched.push_back(mk(0, 1, 1, '0, 1'($urandom), WS'($urandom), NN));  // done pulse
    sched.push_back(mk(0, 0, 0, '0, 1'b0, WS'($urandom), NN));          // back to idle
  endtask

  task automatic run_seq(input int mode, input bit glitch);
    int  done_cnt = 0;
    int  done_idx = -1;
    int  wb1_idx  = -1;
    bit  glitched = 1'b0;
    build_seq(mode);
    $display("sequence mode=%0d glitch=%0d steps=%0d", mode, glitch, sched.size());
    @(posedge clk);
    chk("idle_ready", 64'(bus.DATA_READY), 64'(0));
    chk("idle_busy", 64'(bus.BUSY), 64'(0));
    bus.START      = 1'b1;
    bus.DATA_VALID = 1'($urandom);
    bus.DATA_IN    = WS'($urandom);
    for (int i = 0; i < sched.size(); i++) begin
      @(posedge clk);
      bus.START = 1'b0;
      if (glitch && !glitched && sched[i].nrn == 2 && !sched[i].commit) begin
        bus.START = 1'b1;
        glitched  = 1'b1;
      end
      chk("ready", 64'(bus.DATA_READY), 64'(sched[i].ready));
      chk("busy", 64'(bus.BUSY), 64'(sched[i].busy));
      chk("done", 64'(bus.DONE), 64'(sched[i].done));
      chk("wb_en", 64'(bus.WB_EN), 64'(sched[i].wben));
      if (sched[i].commit) begin
        chk("weights", 64'($unsigned(bus.WEIGHTS_OUT)), 64'(sched[i].w));
        chk("bias", 64'($unsigned(bus.BIAS_OUT)), 64'(sched[i].b));
        $display("commit nrn=%0d wb_en=%b weights=%h bias=%h",
                 sched[i].nrn, bus.WB_EN, bus.WEIGHTS_OUT, bus.BIAS_OUT);
      end
      if (bus.DONE === 1'b1) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
      if (bus.WB_EN === 4'b0010 && wb1_idx < 0) wb1_idx = i;
      bus.DATA_VALID = sched[i].valid;
      bus.DATA_IN    = sched[i].data;
    end
    chk("done_count", 64'(done_cnt), 64'(1));
    if (mode == 0) chk("done_latency", 64'(done_idx), 64'(NN * (NI + 2) + 1));
    if (mode == 1) chk("stall_delay", 64'(wb1_idx), 64'(2 * (NI + 2) - 1 + 2));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 64'(bus.DATA_READY), 64'(0));
    chk({tag, "_busy"}, 64'(bus.BUSY), 64'(0));
    chk({tag, "_done"}, 64'(bus.DONE), 64'(0));
    chk({tag, "_wb_en"}, 64'(bus.WB_EN), 64'(0));
    chk({tag, "_weights"}, 64'($unsigned(bus.WEIGHTS_OUT)), 64'(0));
    chk({tag, "_bias"}, 64'($unsigned(bus.BIAS_OUT)), 64'(0));
  endtask

  // Reset after the 6th accepted word: neuron 1 must never be committed.
  task automatic run_abort();
    int accepted = 0;
    $display("abort sequence");
    @(posedge clk);
    bus.START      = 1'b1;
    bus.DATA_VALID = 1'b1;
    bus.DATA_IN    = WS'($urandom);
    for (int c = 0; c < 30 && accepted < 6; c++) begin
      @(posedge clk);
      bus.START = 1'b0;
      chk("abort_no_wb1", 64'(bus.WB_EN === 4'b0010), 64'(0));
      if (bus.DATA_READY === 1'b1) accepted++;
      bus.DATA_IN = WS'($urandom);
    end
    chk("abort_words", 64'(accepted), 64'(6));
    @(posedge clk);
    chk("abort_no_wb1", 64'(bus.WB_EN === 4'b0010), 64'(0));
    rst       = 1'b1;
    bus.START = 1'b1;
    @(posedge clk);
    check_zero("abort");
    rst            = 1'b0;
    bus.START      = 1'b0;
    bus.DATA_VALID = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.START      = 1'b1;
    bus.DATA_VALID = 1'b1;
    bus.DATA_IN    = 16'h1234;
    repeat (3) @(posedge clk);
    check_zero("reset");
    rst            = 1'b0;
    bus.START      = 1'b0;
    bus.DATA_VALID = 1'b0;

    run_seq(0, 1'b0);
    run_seq(1, 1'b0);
    run_seq(3, 1'b1);
    run_abort();
    run_seq(0, 1'b0);
    for (int r = 0; r < 4; r++) run_seq(2, 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_wb_loader.md
NEURON_WB_LOADER -- requirements
Module: neuron_wb_loader

Interface
REQ-001 The block SHALL have parameter WEIGHT_SIZE, default 16, giving the width of each weight and bias word.
REQ-002 The block SHALL have parameter NUM_INPUTS, default 3, giving the weights per neuron.
REQ-003 The block SHALL have parameter NUM_NEURONS, default 4, giving the neurons loaded per sequence.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL update on the falling edge of CLOCK_N.
REQ-005 Port CLOCK_N, input, 1 bit: clock, active on its falling edge.
REQ-006 Port RESET, input, 1 bit: synchronous active-high reset.
REQ-007 Port START, input, 1 bit: request a full load sequence.
REQ-008 Port DATA_IN, input, WEIGHT_SIZE bits, signed: coefficient word.
REQ-009 Port DATA_VALID, input, 1 bit: DATA_IN holds a valid word.
REQ-010 Port DATA_READY, output, 1 bit: the loader accepts a word this cycle.
REQ-011 Port WEIGHTS_OUT, output, NUM_INPUTS x WEIGHT_SIZE bits, signed: weight bus to the neurons.
REQ-012 Port BIAS_OUT, output, WEIGHT_SIZE bits, signed: bias bus to the neurons.
REQ-013 Port WB_EN, output, NUM_NEURONS bits: one-hot write-enable, one bit per neuron.
REQ-014 Port BUSY, output, 1 bit: a load sequence is in progress.
REQ-015 Port DONE, output, 1 bit: single-cycle pulse marking sequence completion.

Function
REQ-016 The FSM SHALL have four states: IDLE, COLLECT, COMMIT and FINISH.
REQ-017 IDLE: DATA_READY=0 and BUSY=0; START=1 SHALL clear the word and neuron counters and move to COLLECT.
REQ-018 COLLECT: DATA_READY=1 and BUSY=1; a word is accepted only when DATA_VALID and DATA_READY are both 1 on the same edge.
REQ-019 Word order per neuron SHALL be weight[0] through weight[NUM_INPUTS-1], then bias; neurons SHALL be loaded in order 0 to NUM_NEURONS-1.
REQ-020 Accepted word k<NUM_INPUTS SHALL be written into WEIGHTS_OUT[k]; word k=NUM_INPUTS SHALL be written into BIAS_OUT, and the FSM SHALL move to COMMIT.
REQ-021 DATA_VALID=0 in COLLECT SHALL stall the FSM with no change to the counters or outputs; there is no timeout.
REQ-022 COMMIT lasts exactly one cycle: WB_EN SHALL equal one-hot(neuron counter), DATA_READY=0, and WEIGHTS_OUT/BIAS_OUT SHALL be held stable.
REQ-023 WB_EN SHALL be all-zero in every state except COMMIT.
REQ-024 On leaving COMMIT: if the neuron counter equals NUM_NEURONS-1, the FSM SHALL move to FINISH; otherwise it SHALL increment the neuron counter, clear the word counter and return to COLLECT.
REQ-025 FINISH: DONE=1 for one cycle, BUSY=1; the FSM SHALL then return to IDLE.
REQ-026 START SHALL be ignored outside IDLE; DATA_VALID SHALL be ignored outside COLLECT.
REQ-027 Latency: with DATA_VALID held at 1, DONE SHALL rise NUM_NEURONS*(NUM_INPUTS+2)+1 edges after the edge that samples START (21 at defaults).
REQ-028 Counters SHALL be $clog2-sized and SHALL never exceed NUM_INPUTS (word) or NUM_NEURONS-1 (neuron).
REQ-029 Words SHALL be passed through bit-exact, with no arithmetic, scaling or sign change.

Reset
REQ-030 RESET=1 SHALL force IDLE and clear both counters, with WB_EN=0, DATA_READY=0, BUSY=0, DONE=0, WEIGHTS_OUT=0 and BIAS_OUT=0.
REQ-031 RESET SHALL take priority over START and DATA_VALID on the same edge.
REQ-032 RESET mid-sequence SHALL abort the load with no WB_EN pulse for the partially loaded neuron; neurons already committed keep their values.

Structure
REQ-033 Package tdnn_pkg SHALL hold the FSM state enum and the default WEIGHT_SIZE/NUM_INPUTS constants shared with the neuron.
REQ-034 The block SHALL be a single module with no sub-module; the shadow registers SHALL be WEIGHTS_OUT and BIAS_OUT themselves.

Verification
REQ-035 Scenario: RESET, then START with DATA_VALID=1 streaming 1..16 -> WB_EN pulses 0001, 0010, 0100, 1000; neuron 0 sees WEIGHTS_OUT={1,2,3}, BIAS_OUT=4; neuron 3 sees {13,14,15}, BIAS_OUT=16; DONE on edge 21.
REQ-036 Scenario: DATA_VALID toggled 1,0,1,0 during neuron 1 -> WB_EN=0010 delayed by exactly the number of stall cycles, with no words lost or duplicated.
REQ-037 Scenario: word 0x8000 as weight[2] and 0x7FFF as bias -> the same bit patterns appear on WEIGHTS_OUT[2] and BIAS_OUT during COMMIT.
REQ-038 Scenario: START pulsed during COLLECT of neuron 2 -> ignored; the sequence completes normally with a single DONE.
REQ-039 Scenario: RESET asserted after the 6th accepted word -> WB_EN never reaches 0010; outputs are zero next cycle; a new START restarts at neuron 0.
